key_scan_debounce: RTL
======================

Name: key_scan_debounce

Overview:
Multi-channel key conditioning block, the parametrised successor to the single-key edge detector.
- Per key: synchronises the raw input, normalises polarity, and debounces with a programmable counter.
- Per key: emits one-cycle press, release and long-press pulses, plus a clean level.
- Sits between board pushbuttons and control FSMs. Replaces per-key edge detectors throughout the design.

Parameters:
N_KEYS, 4, number of independent key channels (>=1)
ACTIVE_LOW, 1, 1: raw key reads 0 when pressed; 0: raw key reads 1 when pressed
DEB_CNT, 1000000, consecutive cycles a new level must persist before acceptance (>=2; 20 ms @ 50 MHz)
LONG_CNT, 50000000, cycles of accepted press before key_long fires (>=1; 1 s @ 50 MHz)

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
key_in  input  N_KEYS  raw asynchronous key pins, bit i = channel i
key_state  output  N_KEYS  debounced level, 1 = pressed (polarity-normalised)
key_press  output  N_KEYS  one-cycle pulse on accepted press
key_release  output  N_KEYS  one-cycle pulse on accepted release
key_long  output  N_KEYS  one-cycle pulse once per press after LONG_CNT cycles held

Behaviour:
- Reset is asynchronous, active-low (rst_n). While asserted:
  - All outputs are 0.
  - Sync flops hold the released level.
  - Debounce counter = 0, hold counter = 0, long_done = 0.
- Synchroniser: two flops per channel. Polarity inversion is applied after the second flop when ACTIVE_LOW = 1. Result: s (1 = pressed).
- Debounce, per channel, registered each cycle:
  - s == key_state: deb_cnt <= 0.
  - s != key_state and deb_cnt < DEB_CNT-1: deb_cnt <= deb_cnt + 1.
  - s != key_state and deb_cnt == DEB_CNT-1: key_state <= s, deb_cnt <= 0.
- Any return of s to key_state before acceptance clears the count, so a bounce restarts the window; no partial credit.
- Latency: raw level first captured by sync flop 1 at edge E → key_state changes at edge E+DEB_CNT+1, provided the level held throughout.
- key_press / key_release: registered. Asserted in the same cycle key_state changes 0→1 / 1→0, for exactly one cycle. They are never asserted together on one channel.
- Long press, per channel:
  - Hold counter cleared on the accepted press edge.
  - Increments every cycle while key_state = 1, saturating at LONG_CNT.
  - key_long pulses for one cycle at the edge where the count reaches LONG_CNT, i.e. LONG_CNT cycles after key_press.
  - long_done flag blocks further pulses until release.
- Release before LONG_CNT: no key_long. On release, hold counter and long_done are cleared.
- Widths: deb_cnt is $clog2(DEB_CNT) bits; hold counter is $clog2(LONG_CNT+1) bits. No wrap-around; hold counter saturates.
- Channels are fully independent. Simultaneous events on different channels produce simultaneous pulses, with no arbitration.
- Reset mid-operation:
  - Outputs drop to 0 immediately; no release pulse is generated.
  - If a key is still held after reset deasserts, it is re-debounced and produces a fresh key_press at E+DEB_CNT+1.
- The block holds no other state beyond the per-channel registers above.

Decomposition:
- Package key_pkg:
  - default constants DEB_CNT_20MS_50MHZ = 1000000 and LONG_CNT_1S_50MHZ = 50000000;
  - helper function for counter width.
- Sub-module key_channel: sync, debounce, pulse and long logic for one key, scalar ports.
- Top instantiates N_KEYS key_channel copies via generate and concatenates the outputs.

Test Plan:
(bench parameters: N_KEYS=4, ACTIVE_LOW=1, DEB_CNT=4, LONG_CNT=16)
1. rst_n=0 with key_in=4'b0000 (all pressed) → all outputs 0 throughout. Release rst_n with keys still low → key_press=4'b1111 at edge E+5, key_state=4'b1111.
2. Clean press ch0: key_in[0] 1→0 held → key_press[0] high for one cycle at E+5, no other bits pulse. Release: key_in[0]=1 → key_release[0] pulse at E'+5, key_state[0]=0.
3. Bounce ch1: key_in[1] low 3 cycles, high 1 cycle, low 10 cycles → no pulse from the first 3-cycle burst. Single key_press[1] exactly 5 edges after the final fall.
4. Long ch2: hold 40 cycles → key_press[2], then key_long[2] exactly 16 cycles later, only once. Release → key_release[2]. Repeat with a 10-cycle hold → no key_long[2].
5. Simultaneous: ch0 and ch3 pressed on the same cycle → key_press=4'b1001 in a single cycle. Re-run with ACTIVE_LOW=0 and inverted stimulus → identical outputs.
6. Reset mid-hold: ch2 pressed, counter at 8 → rst_n pulse low → key_state/key_long 0, no key_release. After reset with key still held: fresh key_press[2], then key_long[2] 16 cycles later.

Source files
------------

// File: rtl/key_pkg.sv
// Shared constants and sizing helper for the key conditioning channels.
package key_pkg;

  localparam int DEB_CNT_20MS_50MHZ = 1000000;
  localparam int LONG_CNT_1S_50MHZ  = 50000000;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key: two-flop synchroniser, restartable debounce window, press/release
// pulses and a once-per-press long-hold pulse.
module key_channel
  import key_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int DEB_CNT    = DEB_CNT_20MS_50MHZ,
  parameter int LONG_CNT   = LONG_CNT_1S_50MHZ
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int DEB_W  = cnt_width(DEB_CNT);
  localparam int HOLD_W = cnt_width(LONG_CNT + 1);

  localparam logic              RELEASED  = ACTIVE_LOW;
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CNT - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CNT);
  localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_CNT - 1);

  logic              sync_p0;
  logic              sync_p1;
  logic              s;
  logic              accept;
  logic [DEB_W-1:0]  deb_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              long_done;

  // Stage p0/p1: synchroniser, resting at the released raw level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= RELEASED;
      sync_p1 <= RELEASED;
    end else begin
      sync_p0 <= key_raw;
      sync_p1 <= sync_p0;
    end
  end

  assign s      = sync_p1 ^ RELEASED;
  assign accept = (s != key_state) && (deb_cnt == DEB_LAST);

  // Debounce: any agreement with the current level restarts the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt     <= '0;
      key_state   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_press   <= accept &&  s;
      key_release <= accept && !s;
      if (s == key_state) begin
        deb_cnt <= '0;
      end else if (accept) begin
        key_state <= s;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // Hold timer: a release accepted on the same edge suppresses the long pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt  <= '0;
      long_done <= 1'b0;
      key_long  <= 1'b0;
    end else begin
      key_long <= 1'b0;
      if (accept) begin
        hold_cnt  <= '0;
        long_done <= 1'b0;
      end else if (key_state) begin
        if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
        if ((hold_cnt == HOLD_PRE) && !long_done) begin
          key_long  <= 1'b1;
          long_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/key_scan_debounce.sv
// Multi-key conditioning: N_KEYS independent key_channel instances side by side.
module key_scan_debounce
  import key_pkg::*;
#(
  parameter int N_KEYS     = 4,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int DEB_CNT    = DEB_CNT_20MS_50MHZ,
  parameter int LONG_CNT   = LONG_CNT_1S_50MHZ
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_channel #(
      .ACTIVE_LOW (ACTIVE_LOW),
      .DEB_CNT    (DEB_CNT),
      .LONG_CNT   (LONG_CNT)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_raw     (key_in[i]),
      .key_state   (key_state[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i]),
      .key_long    (key_long[i])
    );
  end

endmodule
